// File: rtl/nano_cpu_ws_pkg.sv
// Shared opcode/state definitions for the nano_cpu_ws core.
// NANO_CPU_WS_MUL_EN adds opcode 8 (MUL) to the ALU group.
package nano_cpu_ws_pkg;

  localparam logic [3:0] OPC_READ   = 4'h0;
  localparam logic [3:0] OPC_WRITE  = 4'h1;
  localparam logic [3:0] OPC_JMP    = 4'h2;
  localparam logic [3:0] OPC_BRANCH = 4'h3;
  localparam logic [3:0] OPC_XOR    = 4'h4;
  localparam logic [3:0] OPC_SUB    = 4'h5;
  localparam logic [3:0] OPC_ADD    = 4'h6;
  localparam logic [3:0] OPC_LESS   = 4'h7;
  localparam logic [3:0] OPC_MUL    = 4'h8;
  localparam logic [3:0] OPC_END    = 4'hF;

  typedef enum logic [3:0] {
    OP_READ   = OPC_READ,
    OP_WRITE  = OPC_WRITE,
    OP_JMP    = OPC_JMP,
    OP_BRANCH = OPC_BRANCH,
    OP_XOR    = OPC_XOR,
    OP_SUB    = OPC_SUB,
    OP_ADD    = OPC_ADD,
    OP_LESS   = OPC_LESS,
    OP_MUL    = OPC_MUL,
    OP_END    = OPC_END
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_LD, S_WRITE, S_ALU, S_JMP, S_BRANCH, S_HALT
  } state_e;

  // Any opcode not listed here halts the core.
  function automatic state_e exec_state(input opcode_e op);
    case (op)
      OP_READ:   return S_LD;
      OP_WRITE:  return S_WRITE;
      OP_JMP:    return S_JMP;
      OP_BRANCH: return S_BRANCH;
      OP_XOR, OP_SUB, OP_ADD, OP_LESS: return S_ALU;
`ifdef NANO_CPU_WS_MUL_EN
      OP_MUL:    return S_ALU;
`endif
      default:   return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/nano_cpu_ws_if.sv
// Memory bus of the nano_cpu_ws core: word address, split read/write data,
// ce/we request qualified by a single-cycle ready completion.
interface nano_cpu_ws_if #(parameter int DATA_W = 16);
  logic [7:0]        address;
  logic [DATA_W-1:0] dataR;
  logic [DATA_W-1:0] dataW;
  logic              ce;
  logic              we;
  logic              ready;

  modport master (output address, dataW, ce, we, input dataR, ready);
  modport slave  (input address, dataW, ce, we, output dataR, ready);
endinterface

// File: rtl/nano_cpu_ws_reg_n.sv
// Generic W-bit register with write enable and synchronous active-low clear;
// used for PC, IR and every general register.
module reg_n #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb q_d = en ? d : q_q;

  always_ff @(posedge ck) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/nano_cpu_ws.sv
// Multi-cycle accumulator-free nano CPU: fetch/exec FSM over an 8-bit address
// space. Define NANO_CPU_WS_MUL_EN to enable the MUL (opcode 8) instruction.
module nano_cpu_ws
  import nano_cpu_ws_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4
) (
  input  logic            ck,
  input  logic            rst,
  nano_cpu_ws_if.master   bus,
  output logic            halted
);
  localparam int RW = (NREGS == 4) ? 2 : 1;

  state_e state_q, state_d;

  logic [7:0]  pc_q, pc_d;
  logic        pc_we;
  logic [15:0] ir_q;
  logic        ir_we;

  logic [NREGS-1:0][DATA_W-1:0] rf_q;
  logic [NREGS-1:0]             rf_we;
  logic [DATA_W-1:0]            rf_wd;

  opcode_e     op;
  logic [7:0]  tgt;
  logic [RW-1:0] dst, src1, src2;
  logic [DATA_W-1:0] opa, opb, alu_res;
  logic        unused_ir;

  assign op   = opcode_e'(ir_q[15:12]);
  assign tgt  = ir_q[11:4];
  assign dst  = ir_q[8 +: RW];
  assign src1 = ir_q[4 +: RW];
  assign src2 = ir_q[0 +: RW];
  assign opa  = rf_q[src1];
  assign opb  = rf_q[src2];
  // IR[3:2] carry no meaning; register fields are narrowed for NREGS=2.
  assign unused_ir = ^ir_q;

  reg_n #(.W(8))  u_pc (.ck(ck), .rst(rst), .en(pc_we), .d(pc_d), .q(pc_q));
  reg_n #(.W(16)) u_ir (.ck(ck), .rst(rst), .en(ir_we), .d(bus.dataR[15:0]), .q(ir_q));

  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    reg_n #(.W(DATA_W)) u_r (.ck(ck), .rst(rst), .en(rf_we[i]), .d(rf_wd), .q(rf_q[i]));
  end

`ifdef NANO_CPU_WS_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};
`endif

  always_comb begin
    alu_res = '0;
    case (op)
      OP_XOR:  alu_res = opa ^ opb;
      OP_SUB:  alu_res = opa - opb;
      OP_ADD:  alu_res = opa + opb;
      OP_LESS: alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
`ifdef NANO_CPU_WS_MUL_EN
      OP_MUL:  alu_res = prod[DATA_W-1:0];
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    pc_d    = pc_q + 8'd1;
    ir_we   = 1'b0;
    rf_we   = '0;
    rf_wd   = alu_res;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.ready) begin
        ir_we   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = exec_state(op);
      S_LD:    if (bus.ready) begin
        rf_we[src2] = 1'b1;
        rf_wd       = bus.dataR;
        pc_we       = 1'b1;
        state_d     = S_FETCH;
      end
      S_WRITE: if (bus.ready) begin
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_ALU: begin
        rf_we[dst] = 1'b1;
        pc_we      = 1'b1;
        state_d    = S_FETCH;
      end
      S_JMP: begin
        pc_d    = tgt;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (opb != '0) pc_d = tgt;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Outputs are forced quiet while rst is low, even before the clearing edge.
  assign bus.ce      = rst && (state_q == S_FETCH || state_q == S_LD || state_q == S_WRITE);
  assign bus.we      = rst && (state_q == S_WRITE);
  assign bus.address = !rst ? 8'h00 : ((state_q == S_FETCH) ? pc_q : tgt);
  assign bus.dataW   = rst ? opb : '0;
  assign halted      = rst && (state_q == S_HALT);

endmodule

// File: tb/tb_nano_cpu_ws.sv
// Directed-program bench: an ISA-level interpreter predicts every bus access
// and the final architectural state; a memory responder checks each access.
module tb_nano_cpu_ws;
  import nano_cpu_ws_pkg::*;

  localparam int DW = 16;

  logic ck = 1'b0;
  logic rst = 1'b0;
  logic halted;

  nano_cpu_ws_if #(.DATA_W(DW)) bus();
  nano_cpu_ws #(.DATA_W(DW), .NREGS(4)) dut (.ck(ck), .rst(rst), .bus(bus), .halted(halted));

  always #5 ck = ~ck;

  typedef struct packed {
    logic [7:0]  a;
    logic        w;
    logic [15:0] d;
  } acc_t;

  logic [15:0] mem [256];
  acc_t        exp_q [$];
  logic [15:0] m_reg [4];
  logic [7:0]  m_pc;
  bit          m_halt;

  int total = 0;
  int bad   = 0;
  int stall_n = 0;
  int cnt = 0;
  bit chk_en = 1'b0;
  bit in_stall = 1'b0;
  logic [7:0]  st_addr;
  logic        st_we;
  logic [15:0] st_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mi(input logic [3:0] op, input logic [7:0] a, input logic [1:0] r);
    return {op, a, 2'b00, r};
  endfunction

  function automatic logic [15:0] ai(input logic [3:0] op, input logic [1:0] d,
                                     input logic [1:0] s1, input logic [1:0] s2);
    return {op, 2'b00, d, 2'b00, s1, 2'b00, s2};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = {OPC_END, 12'h000};
  endtask

  // Instruction-set interpreter over a private copy of memory.
  task automatic run_model();
    logic [15:0] m [256];
    logic [15:0] ins;
    logic [7:0]  a;
    logic [1:0]  d, s1, s2;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
    m_pc = 8'h00;
    m_halt = 1'b0;
    exp_q.delete();
    for (int step = 0; step < 1000 && !m_halt; step++) begin
      ins = m[m_pc];
      exp_q.push_back(acc_t'{m_pc, 1'b0, 16'h0});
      a  = ins[11:4];
      d  = ins[9:8];
      s1 = ins[5:4];
      s2 = ins[1:0];
      case (ins[15:12])
        4'h0: begin exp_q.push_back(acc_t'{a, 1'b0, 16'h0}); m_reg[s2] = m[a]; m_pc++; end
        4'h1: begin exp_q.push_back(acc_t'{a, 1'b1, m_reg[s2]}); m[a] = m_reg[s2]; m_pc++; end
        4'h2: m_pc = a;
        4'h3: m_pc = (m_reg[s2] != 0) ? a : m_pc + 8'd1;
        4'h4: begin m_reg[d] = m_reg[s1] ^ m_reg[s2]; m_pc++; end
        4'h5: begin m_reg[d] = m_reg[s1] - m_reg[s2]; m_pc++; end
        4'h6: begin m_reg[d] = m_reg[s1] + m_reg[s2]; m_pc++; end
        4'h7: begin m_reg[d] = (m_reg[s1] < m_reg[s2]) ? 16'd1 : 16'd0; m_pc++; end
`ifdef NANO_CPU_WS_MUL_EN
        4'h8: begin m_reg[d] = m_reg[s1] * m_reg[s2]; m_pc++; end
`endif
        default: m_halt = 1'b1;
      endcase
    end
  endtask

  // Memory responder and per-access compare, evaluated mid-cycle.
  always @(negedge ck) begin
    if (rst && bus.ce) begin
      if (in_stall) begin
        check("stall_addr", 32'(bus.address), 32'(st_addr));
        check("stall_we", 32'(bus.we), 32'(st_we));
        if (st_we) check("stall_dataW", 32'(bus.dataW), 32'(st_d));
      end else begin
        st_addr = bus.address;
        st_we   = bus.we;
        st_d    = bus.dataW;
      end
      if (cnt >= stall_n) begin
        bus.ready = 1'b1;
        bus.dataR = mem[bus.address];
        cnt = 0;
        in_stall = 1'b0;
        if (bus.we) mem[bus.address] = bus.dataW;
        if (chk_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_access: got addr %h want no access", bus.address);
          end else begin
            acc_t e;
            e = exp_q.pop_front();
            check("acc_addr", 32'(bus.address), 32'(e.a));
            check("acc_we", 32'(bus.we), 32'(e.w));
            if (e.w) check("acc_dataW", 32'(bus.dataW), 32'(e.d));
          end
        end
      end else begin
        bus.ready = 1'b0;
        cnt++;
        in_stall = 1'b1;
      end
    end else begin
      bus.ready = 1'b0;
      cnt = 0;
      in_stall = 1'b0;
    end
  end

  task automatic hold_reset();
    @(posedge ck); #1 rst = 1'b0;
    @(negedge ck);
    check("rst_ce", 32'(bus.ce), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_address", 32'(bus.address), 32'd0);
    @(posedge ck); #1;
    check("rst_pc", 32'(dut.pc_q), 32'd0);
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge ck);
      n++;
    end
    if (!halted) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got halted=0 want halted=1", tag);
    end
    // HALT must be absorbing: no further requests.
    repeat (4) begin
      @(negedge ck);
      check("halt_ce", 32'(bus.ce), 32'd0);
    end
    check("halted", 32'(halted), 32'(m_halt));
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("final_pc", 32'(dut.pc_q), 32'(m_pc));
    for (int i = 0; i < 4; i++) check("final_reg", 32'(dut.rf_q[i]), 32'(m_reg[i]));
    chk_en = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int stalls);
    run_model();
    stall_n = stalls;
    hold_reset();
    rst = 1'b1;
    chk_en = 1'b1;
    run_to_halt(tag);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = mi(OPC_READ, 8'h10, 2'd0);
    mem[1] = mi(OPC_READ, 8'h11, 2'd1);
    mem[2] = ai(OPC_SUB, 2'd2, 2'd0, 2'd1);
    mem[3] = mi(OPC_WRITE, 8'h12, 2'd2);
    mem[4] = {OPC_END, 12'h000};
    mem[8'h10] = 16'd5;
    mem[8'h11] = 16'd3;
  endtask

  initial begin
    // Basic program, zero wait states.
    load_basic();
    run_prog("basic", 0);
    check("basic_mem12", 32'(mem[8'h12]), 32'h2);
    check("basic_pc", 32'(dut.pc_q), 32'h4);
    check("basic_halt", 32'(halted), 32'h1);

    // Same program with three wait cycles on every access.
    load_basic();
    run_prog("stall", 3);
    check("stall_mem12", 32'(mem[8'h12]), 32'h2);
    check("stall_pc", 32'(dut.pc_q), 32'h4);

    // ALU boundaries.
    clear_mem();
    mem[0]  = mi(OPC_READ, 8'h20, 2'd0);
    mem[1]  = mi(OPC_READ, 8'h21, 2'd1);
    mem[2]  = ai(OPC_SUB, 2'd2, 2'd0, 2'd1);
    mem[3]  = mi(OPC_WRITE, 8'h30, 2'd2);
    mem[4]  = ai(OPC_LESS, 2'd3, 2'd0, 2'd1);
    mem[5]  = mi(OPC_WRITE, 8'h31, 2'd3);
    mem[6]  = mi(OPC_READ, 8'h22, 2'd0);
    mem[7]  = mi(OPC_READ, 8'h23, 2'd1);
    mem[8]  = ai(OPC_LESS, 2'd3, 2'd0, 2'd1);
    mem[9]  = mi(OPC_WRITE, 8'h32, 2'd3);
    mem[10] = ai(OPC_ADD, 2'd2, 2'd0, 2'd1);
    mem[11] = mi(OPC_WRITE, 8'h33, 2'd2);
    mem[12] = ai(OPC_XOR, 2'd2, 2'd0, 2'd1);
    mem[13] = mi(OPC_WRITE, 8'h34, 2'd2);
    mem[8'h20] = 16'd3;
    mem[8'h21] = 16'd5;
    mem[8'h22] = 16'hFFFF;
    mem[8'h23] = 16'd1;
    run_prog("alu", 1);
    check("sub_3_5", 32'(mem[8'h30]), 32'hFFFE);
    check("less_3_5", 32'(mem[8'h31]), 32'h1);
    check("less_ffff_1", 32'(mem[8'h32]), 32'h0);
    check("add_wrap", 32'(mem[8'h33]), 32'h0);
    check("xor", 32'(mem[8'h34]), 32'hFFFE);

    // Branch taken/not taken, JMP placed at 0xFF back to 0x00.
    clear_mem();
    mem[0]     = mi(OPC_READ, 8'h50, 2'd3);
    mem[1]     = mi(OPC_BRANCH, 8'h08, 2'd3);
    mem[8'h08] = mi(OPC_BRANCH, 8'h30, 2'd2);
    mem[8'h09] = mi(OPC_JMP, 8'hFE, 2'd0);
    mem[8'hFE] = mi(OPC_WRITE, 8'h50, 2'd2);
    mem[8'hFF] = mi(OPC_JMP, 8'h00, 2'd0);
    mem[8'h50] = 16'd7;
    run_prog("branch", 0);
    check("branch_pc", 32'(dut.pc_q), 32'h2);
    check("branch_mem50", 32'(mem[8'h50]), 32'h0);

    // PC increment wraps 0xFF -> 0x00.
    clear_mem();
    mem[0]     = mi(OPC_BRANCH, 8'h10, 2'd1);
    mem[1]     = mi(OPC_JMP, 8'hFF, 2'd0);
    mem[8'hFF] = mi(OPC_READ, 8'h60, 2'd1);
    mem[8'h10] = mi(OPC_WRITE, 8'h61, 2'd1);
    mem[8'h60] = 16'h1234;
    run_prog("wrap", 2);
    check("wrap_pc", 32'(dut.pc_q), 32'h11);
    check("wrap_mem61", 32'(mem[8'h61]), 32'h1234);

    // Opcode 8 with operands 7 and 6.
    clear_mem();
    mem[0] = mi(OPC_READ, 8'h70, 2'd0);
    mem[1] = mi(OPC_READ, 8'h71, 2'd1);
    mem[2] = ai(OPC_MUL, 2'd2, 2'd0, 2'd1);
    mem[3] = mi(OPC_WRITE, 8'h72, 2'd2);
    mem[8'h70] = 16'd7;
    mem[8'h71] = 16'd6;
    mem[8'h72] = 16'h0000;
    run_prog("mul", 0);
`ifdef NANO_CPU_WS_MUL_EN
    check("mul_mem72", 32'(mem[8'h72]), 32'd42);
    check("mul_pc", 32'(dut.pc_q), 32'h4);
`else
    check("mul_halt_pc", 32'(dut.pc_q), 32'h2);
    check("mul_halt", 32'(halted), 32'h1);
`endif

    // Reset while a READ is stalled: no register write, restart from 0.
    clear_mem();
    mem[0]     = mi(OPC_READ, 8'h20, 2'd1);
    mem[8'h20] = 16'h0055;
    run_model();
    stall_n = 50;
    hold_reset();
    rst = 1'b1;
    begin
      int n;
      n = 0;
      while (!(bus.ce && bus.address == 8'h20) && n < 500) begin
        @(negedge ck);
        n++;
      end
      check("abort_reached_ld", 32'(bus.ce && bus.address == 8'h20), 32'h1);
    end
    repeat (3) @(negedge ck);
    @(posedge ck); #1 rst = 1'b0;
    @(negedge ck);
    check("abort_rst_ce", 32'(bus.ce), 32'd0);
    check("abort_rst_addr", 32'(bus.address), 32'd0);
    @(posedge ck); #1;
    check("abort_reg1", 32'(dut.rf_q[1]), 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(S_IDLE));
    stall_n = 0;
    chk_en = 1'b1;
    rst = 1'b1;
    run_to_halt("abort");
    check("abort_final_reg1", 32'(dut.rf_q[1]), 32'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
